// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Runs the host request-to-send sequence (inhibit, start, 8 data bits LSB
// first, odd parity, stop, device ACK) and drives the open-drain PS/2 pins
// through output-enable lines. A timeout covers everything after the clock
// line is released.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 750000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] cmd_data,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_error
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [INH_W-1:0] INH_MAX  = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [INH_W-1:0] INH_ZERO = INH_W'(0);
   localparam logic [INH_W-1:0] INH_ONE  = INH_W'(1);
   localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_ZERO  = TO_W'(0);
   localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_INHIBIT   = 3'd1,
      S_START     = 3'd2,
      S_SEND      = 3'd3,
      S_WAIT_ACK  = 3'd4,
      S_WAIT_IDLE = 3'd5,
      S_DONE      = 3'd6,
      S_ERR       = 3'd7
   } state_e;

   // Odd parity bit: 1 when the byte holds an even number of ones.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

   state_e           state_q;
   logic [9:0]       shift_q;
   logic [3:0]       bitcnt_q;
   logic [INH_W-1:0] inh_cnt_q;
   logic [TO_W-1:0]  to_cnt_q;
   logic             clk_oe_q;
   logic             dat_oe_q;
   logic             done_q;
   logic             err_q;

   logic             clk_meta_q;
   logic             clk_sync_q;
   logic             clk_prev_q;
   logic             dat_meta_q;
   logic             dat_sync_q;

   logic             accept_s;
   logic             fall_s;
   logic             to_zero_s;

   assign cmd_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign accept_s   = cmd_valid & cmd_ready;
   assign fall_s     = clk_prev_q & ~clk_sync_q;
   assign to_zero_s  = (to_cnt_q == TO_ZERO);

   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;
   assign tx_done    = done_q;
   assign tx_error   = err_q;

   // Two-flop synchronizers for both pads plus the previous clock sample for edge detection; idle bus reads high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clk_meta_q <= 1'b1;
         clk_sync_q <= 1'b1;
         clk_prev_q <= 1'b1;
         dat_meta_q <= 1'b1;
         dat_sync_q <= 1'b1;
      end else begin
         clk_meta_q <= ps2_clk_in;
         clk_sync_q <= clk_meta_q;
         clk_prev_q <= clk_sync_q;
         dat_meta_q <= ps2_dat_in;
         dat_sync_q <= dat_meta_q;
      end
   end

   // Transmit sequencer with registered pin enables and status pulses; the timeout has priority over bus events.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         shift_q   <= 10'd0;
         bitcnt_q  <= 4'd0;
         inh_cnt_q <= INH_ZERO;
         to_cnt_q  <= TO_ZERO;
         clk_oe_q  <= 1'b0;
         dat_oe_q  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               clk_oe_q <= 1'b0;
               dat_oe_q <= 1'b0;
               if (accept_s) begin
                  shift_q   <= {1'b1, odd_parity(cmd_data), cmd_data};
                  inh_cnt_q <= INH_MAX;
                  clk_oe_q  <= 1'b1;
                  state_q   <= S_INHIBIT;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_INHIBIT: begin
               if (inh_cnt_q == INH_ZERO) begin
                  dat_oe_q <= 1'b1;
                  state_q  <= S_START;
               end else begin
                  inh_cnt_q <= inh_cnt_q - INH_ONE;
               end
            end
            S_START: begin
               clk_oe_q <= 1'b0;
               bitcnt_q <= 4'd0;
               to_cnt_q <= TO_MAX;
               state_q  <= S_SEND;
            end
            S_SEND: begin
               if (to_zero_s) begin
                  clk_oe_q <= 1'b0;
                  dat_oe_q <= 1'b0;
                  err_q    <= 1'b1;
                  state_q  <= S_ERR;
               end else begin
                  to_cnt_q <= to_cnt_q - TO_ONE;
                  if (fall_s) begin
                     dat_oe_q <= ~shift_q[0];
                     shift_q  <= {1'b0, shift_q[9:1]};
                     if (bitcnt_q == 4'd9) begin
                        state_q <= S_WAIT_ACK;
                     end else begin
                        bitcnt_q <= bitcnt_q + 4'd1;
                     end
                  end else begin
                     state_q <= S_SEND;
                  end
               end
            end
            S_WAIT_ACK: begin
               if (to_zero_s) begin
                  clk_oe_q <= 1'b0;
                  dat_oe_q <= 1'b0;
                  err_q    <= 1'b1;
                  state_q  <= S_ERR;
               end else begin
                  to_cnt_q <= to_cnt_q - TO_ONE;
                  if (fall_s) begin
                     if (!dat_sync_q) begin
                        state_q <= S_WAIT_IDLE;
                     end else begin
                        dat_oe_q <= 1'b0;
                        err_q    <= 1'b1;
                        state_q  <= S_ERR;
                     end
                  end else begin
                     state_q <= S_WAIT_ACK;
                  end
               end
            end
            S_WAIT_IDLE: begin
               if (to_zero_s) begin
                  clk_oe_q <= 1'b0;
                  dat_oe_q <= 1'b0;
                  err_q    <= 1'b1;
                  state_q  <= S_ERR;
               end else begin
                  to_cnt_q <= to_cnt_q - TO_ONE;
                  if (clk_sync_q && dat_sync_q) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_WAIT_IDLE;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            S_ERR: begin
               clk_oe_q <= 1'b0;
               dat_oe_q <= 1'b0;
               state_q  <= S_IDLE;
            end
            default: begin
               clk_oe_q <= 1'b0;
               dat_oe_q <= 1'b0;
               state_q  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 command transmitter: the transmit direction of the PS/2 mouse link, complementing the existing receive path in the mouse top level. It accepts one command byte per valid/ready handshake and performs the full host-initiated PS/2 request-to-send sequence: inhibit, start bit, 8 data bits LSB first, odd parity, stop, device ACK. It drives the open-drain PS2_CLK/PS2_DAT pins through output-enable lines, and the top level ties them to the bidirectional pads. `busy` lets the receive path ignore the bus while a command is in flight.

## Interface
Parameters:
- INHIBIT_CYCLES, 5000, cycles `ps2_clk_oe` is held low before the start bit (100 µs at 50 MHz)
- TIMEOUT_CYCLES, 750000, maximum cycles from clock release to ACK completion (15 ms at 50 MHz)

Ports:
- clk  in  1  system clock (CLOCK_50)
- reset_n  in  1  asynchronous, active-low reset
- cmd_data  in  8  command byte, captured on accept
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready
- ps2_clk_in  in  1  PS2_CLK pad value (asynchronous)
- ps2_dat_in  in  1  PS2_DAT pad value (asynchronous)
- ps2_clk_oe  out  1  1 = pull PS2_CLK low, 0 = release
- ps2_dat_oe  out  1  1 = pull PS2_DAT low, 0 = release
- busy  out  1  high in every state except IDLE
- tx_done  out  1  one-cycle pulse: byte sent and ACK received
- tx_error  out  1  one-cycle pulse: missing ACK or timeout

## Operation
- Input conditioning: 2-flop synchronizers on both pad inputs. A falling edge (`fall`) is prev_sync=1 and sync=0, so it is seen 3 clk cycles after the pad changes.
- On accept, latch cmd_data into a shift register and form frame[9:0] = {1'b1 stop, ~^cmd_data odd parity, cmd_data}. Shift out LSB first.
- IDLE: both oe=0, cmd_ready=1. On accept, go to INHIBIT.
- INHIBIT: clk_oe=1, dat_oe=0. Stay exactly INHIBIT_CYCLES cycles, then go to START.
- START: clk_oe=1, dat_oe=1 (start bit) for exactly 1 cycle. Then go to SEND, release the clock, clear bitcnt, and load the timeout counter.
- SEND: clk_oe=0. On each `fall`, set dat_oe = ~frame[bitcnt] and increment bitcnt. On the `fall` that outputs bit 9 (stop, dat_oe=0), go to WAIT_ACK.
- WAIT_ACK: on the next `fall`, sample dat_sync. If 0, go to WAIT_IDLE. If 1, go to ERR.
- WAIT_IDLE: wait until clk_sync=1 and dat_sync=1, then go to DONE.
- DONE: tx_done=1 for 1 cycle, then IDLE. ERR: tx_error=1 for 1 cycle, oe=0, then IDLE.
- Timeout: counts in SEND, WAIT_ACK and WAIT_IDLE. On expiry, go to ERR and release both lines immediately.
- cmd_valid while not ready is ignored and nothing is queued. cmd_data changes after accept have no effect.

## Timing
- Reset (reset_n=0, asynchronous, effective immediately, including mid-frame): state=IDLE, ps2_clk_oe=0, ps2_dat_oe=0, busy=0, tx_done=0, tx_error=0, cmd_ready=1. Counters and shift register are cleared.
- Accept in cycle N:
  - clk_oe=1 and busy=1 from N+1 through N+INHIBIT_CYCLES
  - dat_oe=1 from N+INHIBIT_CYCLES+1
  - clk_oe=0 from N+INHIBIT_CYCLES+2
- Bit update: dat_oe changes 1 cycle after `fall` is detected, i.e. 4 cycles after the pad falling edge. This is well inside the device's half-period of ≥30 µs.
- Simultaneous timeout expiry and `fall`: timeout wins and goes to ERR. Simultaneous ACK-sample `fall` and all-lines-high: not possible, because the ACK is sampled while clk is low.
- Back-to-back: cmd_ready is high again the cycle after the tx_done or tx_error pulse. The minimum command-to-command spacing is INHIBIT_CYCLES+frame time.
- All outputs are registered except cmd_ready and busy, which are state decodes.

## Test plan
Bench settings: INHIBIT_CYCLES=100, TIMEOUT_CYCLES=20000. The device model clocks at a 1000-cycle period, samples data on rising edges and drives the ACK.
- Send 0xF4 → inhibit exactly 100 cycles. Device samples start 0, bits 0,0,1,0,1,1,1,1, parity 0, stop 1. Device ACK low gives one tx_done pulse and no tx_error; busy falls the same cycle that cmd_ready rises.
- Send 0xFF → sampled parity = 1 (eight ones, odd parity). Send 0x00 → sampled parity = 1. Both produce tx_done.
- Device never clocks after release → tx_error pulse 20000 cycles after START ends. Both oe=0, cmd_ready=1.
- Device leaves data high at the ACK edge → tx_error pulse after the 11th falling edge. No tx_done.
- Hold reset_n low mid-SEND after bit 4 → oe=0 the same cycle (asynchronous). After reset_n returns high, cmd_ready=1 and a new 0xF4 completes normally.
- Hold cmd_valid high during busy with cmd_data changing → exactly one frame per accept, carrying only the latched byte. A second frame starts only after tx_done.
